// File: rtl/utm_pkg.sv
// Shared types and constants for the UTM tape unit.
package utm_pkg;

    localparam int SYM_W = 3;

    typedef logic [SYM_W-1:0] sym_t;

    localparam sym_t SYM_BLANK   = 3'b000;
    localparam sym_t SYM_ILLEGAL = 3'b011;

    typedef enum logic [1:0] {
        MOVE_STAY  = 2'b00,
        MOVE_RIGHT = 2'b01,
        MOVE_LEFT  = 2'b10,
        MOVE_RSVD  = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        FC_NONE      = 2'b00,
        FC_ILL_SYM   = 2'b01,
        FC_EDGE      = 2'b10,
        FC_RSVD_MOVE = 2'b11
    } fault_t;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    // Every 3-bit code except 011 is a valid tape symbol.
    function automatic logic sym_legal(sym_t s);
        return s != SYM_ILLEGAL;
    endfunction

endpackage

// File: rtl/utm_tape_unit_if.sv
// Step-command handshake between the step controller and the tape unit.
interface utm_tape_unit_if;
    import utm_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    sym_t       cmd_sym;
    logic [1:0] cmd_move;

    modport master (output cmd_valid, cmd_wr, cmd_sym, cmd_move, input cmd_ready);
    modport slave  (input cmd_valid, cmd_wr, cmd_sym, cmd_move, output cmd_ready);
endinterface

// File: rtl/utm_tape_ram.sv
// Tape cell store: one synchronous write port, one asynchronous read port.
module utm_tape_ram
    import utm_pkg::*;
#(
    parameter int   TAPE_LEN = 16,
    parameter sym_t BLANK    = SYM_BLANK,
    localparam int  AW       = $clog2(TAPE_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  sym_t          wdata_i,
    input  logic [AW-1:0] raddr_i,
    output sym_t          rdata_o
);

    sym_t cells_q [TAPE_LEN];

    // Clear every cell on reset, otherwise take the single write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPE_LEN; i++) cells_q[i] <= BLANK;
        end else if (we_i) begin
            cells_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = cells_q[raddr_i];

endmodule

// File: rtl/utm_tape_unit.sv
// Tape store for the UTM: serial preload, then one write/move command per cycle.
module utm_tape_unit
    import utm_pkg::*;
#(
    parameter int   TAPE_LEN  = 16,
    parameter int   HEAD_INIT = 0,
    parameter sym_t BLANK     = SYM_BLANK,
    localparam int  HW        = $clog2(TAPE_LEN)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_valid,
    input  sym_t           load_sym,
    input  logic           load_done,
    utm_tape_unit_if.slave cmd,
    output logic           s2,
    output logic           s1,
    output logic           s0,
    output logic [HW-1:0]  head,
    output logic           running,
    output logic           fault,
    output logic [1:0]     fault_code
);

    localparam logic [HW-1:0] HEAD_RST = HEAD_INIT[HW-1:0];
    localparam logic [HW-1:0] LAST     = HW'(TAPE_LEN - 1);

    state_t        state_q, state_d;
    logic [HW-1:0] head_q, head_d;
    logic [HW-1:0] ptr_q, ptr_d;
    fault_t        code_q, code_d;
    logic          cmd_ready_q, running_q, fault_q;

    logic          we;
    logic [HW-1:0] waddr;
    sym_t          wdata;
    sym_t          head_sym;
    move_t         move;

    assign move = move_t'(cmd.cmd_move);

    utm_tape_ram #(.TAPE_LEN(TAPE_LEN), .BLANK(BLANK)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (head_q),
        .rdata_o (head_sym)
    );

    // Next-state: load path in LOAD, command path in RUN, everything frozen in FAULT.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        ptr_d   = ptr_q;
        code_d  = code_q;
        we      = 1'b0;
        waddr   = head_q;
        wdata   = cmd.cmd_sym;
        unique case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    if (!sym_legal(load_sym)) begin
                        state_d = ST_FAULT;
                        code_d  = FC_ILL_SYM;
                    end else begin
                        we    = 1'b1;
                        waddr = ptr_q;
                        wdata = load_sym;
                        // Pointer saturates on the last cell; later loads overwrite it.
                        if (ptr_q != LAST) ptr_d = ptr_q + 1'b1;
                    end
                end
                // A load in the same cycle is done first; a faulting load wins.
                if (load_done && state_d == ST_LOAD) begin
                    state_d = ST_RUN;
                    head_d  = HEAD_RST;
                end
            end
            ST_RUN: begin
                if (cmd.cmd_valid) begin
                    if (move == MOVE_RSVD) begin
                        state_d = ST_FAULT;
                        code_d  = FC_RSVD_MOVE;
                    end else if (cmd.cmd_wr && !sym_legal(cmd.cmd_sym)) begin
                        state_d = ST_FAULT;
                        code_d  = FC_ILL_SYM;
                    end else begin
                        // Write hits the old head cell even if the move faults.
                        we = cmd.cmd_wr;
                        if (move == MOVE_RIGHT) begin
                            if (head_q == LAST) begin
                                state_d = ST_FAULT;
                                code_d  = FC_EDGE;
                            end else begin
                                head_d = head_q + 1'b1;
                            end
                        end else if (move == MOVE_LEFT) begin
                            if (head_q == '0) begin
                                state_d = ST_FAULT;
                                code_d  = FC_EDGE;
                            end else begin
                                head_d = head_q - 1'b1;
                            end
                        end
                    end
                end
            end
            ST_FAULT: ;
            default: state_d = ST_FAULT;
        endcase
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            head_q      <= HEAD_RST;
            ptr_q       <= '0;
            code_q      <= FC_NONE;
            cmd_ready_q <= 1'b0;
            running_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            ptr_q       <= ptr_d;
            code_q      <= code_d;
            cmd_ready_q <= (state_d == ST_RUN);
            running_q   <= (state_d == ST_RUN);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign cmd.cmd_ready    = cmd_ready_q;
    assign {s2, s1, s0}     = head_sym;
    assign head             = head_q;
    assign running          = running_q;
    assign fault            = fault_q;
    assign fault_code       = code_q;

endmodule

// File: tb/tb_utm_tape_unit.sv
// Directed bench for utm_tape_unit with hand-computed expectations.
module tb_utm_tape_unit;
    import utm_pkg::*;

    localparam int TL = 16;

    logic       clk = 1'b0;
    logic       reset, load_valid, load_done;
    logic [2:0] load_sym;
    logic       s2, s1, s0;
    logic [3:0] head;
    logic       running, fault;
    logic [1:0] fault_code;

    utm_tape_unit_if cmd_if ();

    utm_tape_unit #(.TAPE_LEN(TL), .HEAD_INIT(0), .BLANK(3'b000)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_sym   (load_sym),
        .load_done  (load_done),
        .cmd        (cmd_if.slave),
        .s2         (s2),
        .s1         (s1),
        .s0         (s0),
        .head       (head),
        .running    (running),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Full status check: head, symbol under head, running, cmd_ready, fault, code.
    task automatic chk_st(input string tag, input int h, input int s, input int run,
                          input int flt, input int code);
        chk({tag, ".head"},  32'(head), 32'(h));
        chk({tag, ".sym"},   32'({s2, s1, s0}), 32'(s));
        chk({tag, ".run"},   32'(running), 32'(run));
        chk({tag, ".rdy"},   32'(cmd_if.cmd_ready), 32'(run));
        chk({tag, ".fault"}, 32'(fault), 32'(flt));
        chk({tag, ".code"},  32'(fault_code), 32'(code));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_valid       = 1'b0;
        load_sym         = 3'b000;
        load_done        = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_wr    = 1'b0;
        cmd_if.cmd_sym   = 3'b000;
        cmd_if.cmd_move  = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic ld(input logic [2:0] sym);
        load_valid = 1'b1;
        load_sym   = sym;
        step();
        load_valid = 1'b0;
    endtask

    task automatic ldone();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
    endtask

    task automatic cmd(input logic wr, input logic [2:0] sym, input logic [1:0] mv);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_wr    = wr;
        cmd_if.cmd_sym   = sym;
        cmd_if.cmd_move  = mv;
        step();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_wr    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();

        // Reset state, then straight to RUN.
        do_reset();
        chk_st("rst", 0, 0, 0, 0, 0);
        ldone();
        chk_st("run0", 0, 0, 1, 0, 0);

        // Preload three cells and walk right without writing.
        do_reset();
        ld(3'b001); ld(3'b010); ld(3'b100);
        chk("load.run", 32'(running), 32'd0);
        ldone();
        chk_st("ld.h0", 0, 3'b001, 1, 0, 0);
        cmd(1'b0, 3'b000, 2'b01);
        chk_st("ld.h1", 1, 3'b010, 1, 0, 0);
        cmd(1'b0, 3'b000, 2'b01);
        chk_st("ld.h2", 2, 3'b100, 1, 0, 0);

        // Write-then-move, then come back to see the written symbol.
        do_reset();
        ldone();
        cmd(1'b1, 3'b111, 2'b01);
        chk_st("wr.h1", 1, 3'b000, 1, 0, 0);
        cmd(1'b0, 3'b000, 2'b10);
        chk_st("wr.h0", 0, 3'b111, 1, 0, 0);

        // Left edge: write lands, head stays, edge fault; later commands ignored.
        cmd(1'b1, 3'b101, 2'b10);
        chk_st("ledge", 0, 3'b101, 0, 1, 2);
        cmd(1'b1, 3'b110, 2'b01);
        chk_st("frozen", 0, 3'b101, 0, 1, 2);

        // Illegal symbol in RUN: no write, no move.
        do_reset();
        ldone();
        cmd(1'b1, 3'b011, 2'b01);
        chk_st("ill.run", 0, 3'b000, 0, 1, 1);

        // Illegal symbol during load; load_done afterwards is ignored.
        do_reset();
        ld(3'b011);
        chk_st("ill.ld", 0, 3'b000, 0, 1, 1);
        ldone();
        chk_st("ill.ldone", 0, 3'b000, 0, 1, 1);

        // Reserved move: nothing written, head unchanged.
        do_reset();
        ldone();
        cmd(1'b1, 3'b110, 2'b11);
        chk_st("rsvd", 0, 3'b000, 0, 1, 3);

        // Load pointer saturates on the last cell; right edge fault.
        do_reset();
        for (int i = 0; i < TL; i++) ld(3'b001);
        ld(3'b111);
        ldone();
        for (int i = 0; i < TL - 2; i++) cmd(1'b0, 3'b000, 2'b01);
        chk_st("sat.h14", TL - 2, 3'b001, 1, 0, 0);
        cmd(1'b0, 3'b000, 2'b01);
        chk_st("sat.h15", TL - 1, 3'b111, 1, 0, 0);
        cmd(1'b1, 3'b010, 2'b01);
        chk_st("redge", TL - 1, 3'b010, 0, 1, 2);

        // Reset mid-run after five commands clears cells and head.
        do_reset();
        ldone();
        cmd(1'b1, 3'b001, 2'b01);
        cmd(1'b1, 3'b010, 2'b01);
        cmd(1'b1, 3'b100, 2'b01);
        cmd(1'b1, 3'b101, 2'b01);
        cmd(1'b1, 3'b110, 2'b00);
        chk_st("mid.h4", 4, 3'b110, 1, 0, 0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_wr    = 1'b1;
        cmd_if.cmd_sym   = 3'b111;
        cmd_if.cmd_move  = 2'b01;
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        chk_st("mid.rst", 0, 3'b000, 0, 0, 0);
        ldone();
        for (int i = 0; i < 4; i++) begin
            cmd(1'b0, 3'b000, 2'b01);
            chk({"mid.clr", 8'("0" + i)}, 32'({s2, s1, s0}), 32'd0);
        end
        chk("mid.head", 32'(head), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
